// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
//   Shared definitions for the byte-stream program loader: FSM state
//   encoding, failure cause codes and the idle-timeout counter width.
package prog_loader_pkg;

  // Width of the idle-timeout counter.
  localparam int unsigned TMO_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_SUM  = 3'd3,
    ST_RUN  = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_e;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_LEN0    = 3'd1;
  localparam logic [2:0] ERR_OVF     = 3'd2;
  localparam logic [2:0] ERR_SUM     = 3'd3;
  localparam logic [2:0] ERR_ABORT   = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT = 3'd5;

  // A session is active while the loader is consuming stream bytes.
  function automatic logic in_session(input state_e s);
    return (s == ST_LEN) || (s == ST_DATA) || (s == ST_SUM);
  endfunction

endpackage

// File: rtl/prog_loader_timer.sv
// loader_timer
//   Idle-timeout counter for a load session. Counts cycles without a
//   stream transfer and flags expiry once the count reaches TIMEOUT.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous reset, active-low
//   clr     in   clear the count (transfer seen or no session active)
//   run_en  in   count this cycle (session active, no transfer)
//   expired out  count has reached TIMEOUT
module loader_timer #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run_en,
  output logic expired
);
  import prog_loader_pkg::*;

  localparam logic [TMO_W-1:0] TERM_CNT = TMO_W'(TIMEOUT);

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  // Terminal-count compare on the registered value; the count saturates
  // there so it can never wrap back to zero while the FSM reacts.
  assign expired = (cnt_q == TERM_CNT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run_en && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader
//   Byte-stream program loader. Receives a length byte, that many payload
//   bytes and a checksum byte, writes the payload into the CPU RAM starting
//   at BASE_ADDR, and releases the CPU with a one-cycle run pulse when the
//   checksum matches. The CPU is held in await for the whole session and
//   stays held after a failed session.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | after reset, nothing loaded yet
//   LEN   | waiting for the length byte
//   DATA  | receiving payload bytes, one RAM write per byte
//   SUM   | waiting for the checksum byte
//   RUN   | one cycle: CPU released and started
//   DONE  | last session succeeded, CPU running
//   ERR   | last session failed, CPU held, err_code holds the cause
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   start, abort      session control
//   s_valid, s_data   input byte stream; s_ready back-pressure (comb)
//   ram_addr, ram_data_in, ram_wren   registered RAM write port
//   cpu_halt, cpu_run CPU control
//   busy, done, err, err_code         status
module prog_loader #(
  parameter logic [7:0]  BASE_ADDR = 8'h00,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_data_in,
  output logic       ram_wren,
  output logic       cpu_halt,
  output logic       cpu_run,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] err_code
);
  import prog_loader_pkg::*;

  // Largest length that fits between BASE_ADDR and the top of RAM.
  localparam logic [8:0] MAX_LEN = 9'd256 - {1'b0, BASE_ADDR};

  state_e     state_q, state_d;
  logic [2:0] err_code_q, err_code_d;

  logic [7:0] cnt_q, cnt_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] sum_q, sum_d;

  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;

  logic       active;
  logic       xfer;
  logic       tmo_expired;
  logic       accept;

  assign active = in_session(state_q);
  assign xfer   = s_valid && active;
  // A byte only takes effect when neither abort nor timeout win the cycle.
  assign accept = xfer && !abort && !tmo_expired;

  loader_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!active || xfer),
    .run_en  (active && !xfer),
    .expired (tmo_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    if (active) begin
      if (abort) begin
        state_d    = ST_ERR;
        err_code_d = ERR_ABORT;
      end else if (tmo_expired) begin
        state_d    = ST_ERR;
        err_code_d = ERR_TIMEOUT;
      end else if (xfer) begin
        case (state_q)
          ST_LEN: begin
            if (s_data == 8'd0) begin
              state_d    = ST_ERR;
              err_code_d = ERR_LEN0;
            end else if ({1'b0, s_data} > MAX_LEN) begin
              state_d    = ST_ERR;
              err_code_d = ERR_OVF;
            end else begin
              state_d = ST_DATA;
            end
          end
          ST_DATA: begin
            if (cnt_q == 8'd1) begin
              state_d = ST_SUM;
            end
          end
          ST_SUM: begin
            if (s_data == sum_q) begin
              state_d = ST_RUN;
            end else begin
              state_d    = ST_ERR;
              err_code_d = ERR_SUM;
            end
          end
          default: state_d = state_q;
        endcase
      end
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state_d    = ST_LEN;
            err_code_d = ERR_NONE;
          end
        end
        ST_RUN:  state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output logic; everything but the write port is decoded from state.
  always_comb begin
    s_ready     = active;
    busy        = active;
    cpu_halt    = active || (state_q == ST_ERR);
    cpu_run     = (state_q == ST_RUN);
    done        = (state_q == ST_RUN) || (state_q == ST_DONE);
    err         = (state_q == ST_ERR);
    err_code    = err_code_q;
    ram_wren    = wr_en_q;
    ram_addr    = wr_addr_q;
    ram_data_in = wr_data_q;
  end

  // Payload datapath and registered RAM write port.
  always_comb begin
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    sum_d     = sum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (accept && (state_q == ST_LEN)) begin
      cnt_d = s_data;
      ptr_d = BASE_ADDR;
      sum_d = 8'd0;
    end
    if (accept && (state_q == ST_DATA)) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ptr_q;
      wr_data_d = s_data;
      sum_d     = sum_q + s_data;
      ptr_d     = ptr_q + 8'd1;
      cnt_d     = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= 8'd0;
      ptr_q     <= 8'd0;
      sum_q     <= 8'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 8'd0;
      wr_data_q <= 8'd0;
    end else begin
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      sum_q     <= sum_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  localparam int TMO = 1023;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;

  logic       s_ready_a, wren_a, halt_a, run_a, busy_a, done_a, err_a;
  logic [7:0] addr_a, data_a;
  logic [2:0] code_a;
  logic       s_ready_b, wren_b, halt_b, run_b, busy_b, done_b, err_b;
  logic [7:0] addr_b, data_b;
  logic [2:0] code_b;

  int checks = 0;
  int errors = 0;

  typedef logic [15:0] wq_t[$];
  wq_t wq_a;
  wq_t wq_b;
  int  run_cnt_a = 0;
  int  run_cnt_b = 0;

  prog_loader #(.BASE_ADDR(8'h00), .TIMEOUT(TMO)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_a),
    .ram_addr(addr_a), .ram_data_in(data_a), .ram_wren(wren_a),
    .cpu_halt(halt_a), .cpu_run(run_a), .busy(busy_a),
    .done(done_a), .err(err_a), .err_code(code_a)
  );

  prog_loader #(.BASE_ADDR(8'hF0), .TIMEOUT(TMO)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_b),
    .ram_addr(addr_b), .ram_data_in(data_b), .ram_wren(wren_b),
    .cpu_halt(halt_b), .cpu_run(run_b), .busy(busy_b),
    .done(done_b), .err(err_b), .err_code(code_b)
  );

  always #5 clk = ~clk;

  // Write / run monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (wren_a) wq_a.push_back({addr_a, data_a});
    if (wren_b) wq_b.push_back({addr_b, data_b});
    if (run_a) run_cnt_a++;
    if (run_b) run_cnt_b++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_mon();
    wq_a.delete();
    wq_b.delete();
    run_cnt_a = 0;
    run_cnt_b = 0;
  endtask

  task automatic do_start();
    clr_mon();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) begin
      s_valid = 1'b0;
      tick();
    end
    s_valid = 1'b1;
    s_data  = b;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Reference model: payload byte i lands at base+i; checksum is the byte sum mod 256.
  function automatic wq_t model_writes(input logic [7:0] base, input logic [7:0] pl[$], input int n);
    wq_t q;
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + 8'(i);
      q.push_back({a, pl[i]});
    end
    return q;
  endfunction

  function automatic logic [7:0] model_sum(input logic [7:0] pl[$]);
    int s = 0;
    foreach (pl[i]) s += int'(pl[i]);
    return 8'(s % 256);
  endfunction

  task automatic cmp_writes(input string name, input wq_t got, input wq_t exp);
    int n;
    chk({name, "_nwr"}, got.size(), exp.size());
    n = (got.size() < exp.size()) ? got.size() : exp.size();
    for (int i = 0; i < n; i++) chk({name, "_wr"}, got[i], exp[i]);
  endtask

  task automatic run_good(input string name);
    logic [7:0] pl[$];
    pl = '{8'h50, 8'h07, 8'hA1};
    do_start();
    send(8'h03, 0);
    foreach (pl[i]) send(pl[i], 0);
    send(model_sum(pl), 0);
    repeat (3) tick();
    chk({name, "_done"}, done_a, 1'b1);
    chk({name, "_halt"}, halt_a, 1'b0);
    chk({name, "_run"}, run_cnt_a, 1);
    cmp_writes(name, wq_a, model_writes(8'h00, pl, 3));
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ready"}, s_ready_a, 1'b0);
    chk({name, "_addr"}, addr_a, 8'h00);
    chk({name, "_data"}, data_a, 8'h00);
    chk({name, "_wren"}, wren_a, 1'b0);
    chk({name, "_halt"}, halt_a, 1'b0);
    chk({name, "_run"}, run_a, 1'b0);
    chk({name, "_busy"}, busy_a, 1'b0);
    chk({name, "_done"}, done_a, 1'b0);
    chk({name, "_err"}, err_a, 1'b0);
    chk({name, "_code"}, code_a, 3'd0);
  endtask

  typedef struct {
    int         n;
    logic [7:0] b[8];
    int         exp_wr;
    logic [2:0] exp_code;
    logic       exp_done;
  } vec_t;

  vec_t tv[5];

  initial begin
    logic [7:0] pl[$];
    logic [7:0] sb;
    logic       good;
    int         len, k;
    logic       early;

    tv[0] = '{5, '{8'h03, 8'h50, 8'h07, 8'hA1, 8'hF8, 8'h00, 8'h00, 8'h00}, 3, 3'd0, 1'b1};
    tv[1] = '{5, '{8'h03, 8'h50, 8'h07, 8'hA1, 8'hF9, 8'h00, 8'h00, 8'h00}, 3, 3'd3, 1'b0};
    tv[2] = '{1, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 3'd1, 1'b0};
    tv[3] = '{3, '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 3'd0, 1'b1};
    tv[4] = '{4, '{8'h02, 8'hFF, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 3'd0, 1'b1};

    // Reset state
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b1;
    tick();

    // Table-driven sessions, bytes back-to-back
    foreach (tv[v]) begin
      do_start();
      chk("tv_halt_on_start", halt_a, 1'b1);
      chk("tv_busy_on_start", busy_a, 1'b1);
      for (int i = 0; i < tv[v].n; i++) send(tv[v].b[i], 0);
      repeat (3) tick();
      chk("tv_done", done_a, tv[v].exp_done);
      chk("tv_err", err_a, !tv[v].exp_done);
      chk("tv_code", code_a, tv[v].exp_code);
      chk("tv_halt", halt_a, !tv[v].exp_done);
      chk("tv_run", run_cnt_a, tv[v].exp_done ? 1 : 0);
      chk("tv_busy", busy_a, 1'b0);
      pl.delete();
      for (int i = 0; i < tv[v].exp_wr; i++) pl.push_back(tv[v].b[i + 1]);
      cmp_writes("tv", wq_a, model_writes(8'h00, pl, tv[v].exp_wr));
    end

    // Abort mid-payload with a byte offered in the same cycle
    do_start();
    send(8'h05, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    s_valid = 1'b1;
    s_data  = 8'h33;
    abort   = 1'b1;
    tick();
    abort   = 1'b0;
    s_valid = 1'b0;
    repeat (3) tick();
    chk("abort_err", err_a, 1'b1);
    chk("abort_code", code_a, 3'd4);
    chk("abort_halt", halt_a, 1'b1);
    pl = '{8'h11, 8'h22};
    cmp_writes("abort", wq_a, model_writes(8'h00, pl, 2));
    run_good("after_abort");

    // Idle timeout after one payload byte
    do_start();
    send(8'h02, 0);
    send(8'hAA, 0);
    early = 1'b0;
    repeat (TMO - 2) begin
      tick();
      if (err_a || !busy_a) early = 1'b1;
    end
    chk("tmo_early", early, 1'b0);
    k = 0;
    while (!err_a && k < 50) begin
      tick();
      k++;
    end
    chk("tmo_reached", err_a, 1'b1);
    chk("tmo_code", code_a, 3'd5);
    chk("tmo_halt", halt_a, 1'b1);
    pl = '{8'hAA};
    cmp_writes("tmo", wq_a, model_writes(8'h00, pl, 1));

    // Reset asserted the cycle after a payload byte is accepted
    do_start();
    send(8'h03, 0);
    send(8'h50, 0);
    chk("rst_pre_wren", wren_a, 1'b1);
    rst = 1'b0;
    tick();
    chk_all_zero("rst_mid");
    rst = 1'b1;
    tick();
    run_good("after_rst");

    // Length overflow and exact-fit boundary with BASE_ADDR=F0
    pulse_rst();
    do_start();
    send(8'h11, 0);
    tick();
    chk("ovf_err", err_b, 1'b1);
    chk("ovf_code", code_b, 3'd2);
    chk("ovf_halt", halt_b, 1'b1);
    chk("ovf_base0_busy", busy_a, 1'b1);
    pulse_rst();
    pl.delete();
    for (int i = 0; i < 16; i++) pl.push_back(8'($urandom));
    do_start();
    send(8'h10, 0);
    foreach (pl[i]) send(pl[i], 0);
    send(model_sum(pl), 0);
    repeat (3) tick();
    chk("fit_done", done_b, 1'b1);
    chk("fit_run", run_cnt_b, 1);
    cmp_writes("fit_b", wq_b, model_writes(8'hF0, pl, 16));
    cmp_writes("fit_a", wq_a, model_writes(8'h00, pl, 16));

    // Random sessions with short gaps
    for (int r = 0; r < 25; r++) begin
      len  = $urandom_range(1, 12);
      good = 1'($urandom_range(0, 1));
      pl.delete();
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      sb = model_sum(pl);
      if (!good) sb = sb ^ 8'($urandom_range(1, 255));
      do_start();
      send(8'(len), $urandom_range(0, 3));
      foreach (pl[i]) send(pl[i], $urandom_range(0, 3));
      send(sb, $urandom_range(0, 3));
      repeat (3) tick();
      chk("rnd_done", done_a, good);
      chk("rnd_code", code_a, good ? 3'd0 : 3'd3);
      chk("rnd_halt", halt_a, !good);
      chk("rnd_run", run_cnt_a, good ? 1 : 0);
      cmp_writes("rnd", wq_a, model_writes(8'h00, pl, len));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
